// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter sharing one free-running 16-bit XNOR LFSR among NREQ
// requesters, with seeding, warm-up, minimum grant spacing and lockup recovery.
module lfsr16 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] seed_i,
    output logic [15:0] q_o
);
    logic [15:0] q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) q_q <= seed_i;
        else       q_q <= {q_q[14:0], ~(q_q[15] ^ q_q[14] ^ q_q[12] ^ q_q[3])};
    end

    assign q_o = q_q;
endmodule

module lfsr_arbiter #(
    parameter int          NREQ         = 4,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
    parameter int          WARM         = 16,
    parameter int          GAP          = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     seed_in,
    input  logic            seed_load,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [15:0]     rnd_data,
    output logic            rnd_valid,
    output logic            busy,
    output logic            lockup_err
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {S_INIT, S_SEED, S_WARM, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [15:0]     seed_reg_q, seed_reg_d;
    logic [7:0]      warm_cnt_q, warm_cnt_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            lockup_q, lockup_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rnd_valid_q, rnd_valid_d;
    logic [15:0]     rnd_data_q, rnd_data_d;

    logic [15:0]     lfsr_q;
    logic            lfsr_rst;
    logic            req_hit;
    logic [PW-1:0]   sel, cand, nxt_ptr;
    int              idx;

    assign lfsr_rst = (state_q == S_INIT) || (state_q == S_SEED);

    lfsr16 u_lfsr (
        .clk_i  (clk),
        .rst_i  (lfsr_rst),
        .seed_i (seed_reg_q),
        .q_o    (lfsr_q)
    );

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        req_hit = 1'b0;
        sel     = '0;
        cand    = '0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = PW'(idx);
            if (!req_hit && req[cand]) begin
                req_hit = 1'b1;
                sel     = cand;
            end
        end
        nxt_ptr = (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        seed_reg_d  = seed_reg_q;
        warm_cnt_d  = warm_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        lockup_d    = lockup_q;
        gnt_d       = '0;
        rnd_valid_d = 1'b0;
        rnd_data_d  = rnd_data_q;

        case (state_q)
            S_INIT, S_SEED: begin
                warm_cnt_d = '0;
                state_d    = S_WARM;
            end
            S_WARM: begin
                if (warm_cnt_q == 8'(WARM - 1)) begin
                    state_d   = S_RUN;
                    gap_cnt_d = 8'(GAP - 1);
                end else begin
                    warm_cnt_d = warm_cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                if (lfsr_q == 16'hFFFF) begin
                    lockup_d   = 1'b1;
                    seed_reg_d = DEFAULT_SEED;
                    state_d    = S_SEED;
                end else if (gap_cnt_q == 8'(GAP - 1)) begin
                    if (req_hit) begin
                        gnt_d[sel]  = 1'b1;
                        rnd_valid_d = 1'b1;
                        rnd_data_d  = lfsr_q;
                        rr_ptr_d    = nxt_ptr;
                        gap_cnt_d   = '0;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = S_INIT;
        endcase

        // A reseed request wins over any grant or lockup action this cycle.
        if (seed_load) begin
            seed_reg_d  = (seed_in == 16'hFFFF) ? DEFAULT_SEED : seed_in;
            lockup_d    = 1'b0;
            state_d     = S_SEED;
            gnt_d       = '0;
            rnd_valid_d = 1'b0;
            rnd_data_d  = rnd_data_q;
            rr_ptr_d    = rr_ptr_q;
            gap_cnt_d   = gap_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_INIT;
            seed_reg_q  <= DEFAULT_SEED;
            warm_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            lockup_q    <= 1'b0;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            seed_reg_q  <= seed_reg_d;
            warm_cnt_q  <= warm_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            lockup_q    <= lockup_d;
            gnt_q       <= gnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
        end
    end

    assign gnt        = gnt_q;
    assign rnd_valid  = rnd_valid_q;
    assign rnd_data   = rnd_data_q;
    assign lockup_err = lockup_q;
    assign busy       = (state_q != S_RUN);
endmodule
